// File: rtl/adxl362_poll_ctrl.sv
// Periodic ADXL362 burst-read sequencer on an MMIO slot; commits X/Y/Z atomically to CPU registers.
// Optional ADXL_TEMP_EN macro extends each frame with TEMP_L/TEMP_H and exposes register 7 TEMP.
module adxl362_poll_ctrl #(
  parameter int SS_SETUP_CYC = 2,
  parameter int SS_HOLD_CYC  = 4,
  parameter int PERIOD_W     = 24,
  parameter int RESET_PERIOD = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_spi_start,
  output logic [7:0]  o_spi_wr_byte,
  input  logic [7:0]  i_spi_rd_byte,
  input  logic        i_spi_ready,
  output logic        o_spi_ss_n,
  output logic        o_irq
);

`ifdef ADXL_TEMP_EN
  localparam int NDATA = 8;
`else
  localparam int NDATA = 6;
`endif
  localparam int NBYTES = NDATA + 2;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_COMMIT, S_HOLD} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cyc_cnt;
  logic [3:0]            r_byte_idx;
  logic                  r_seen_low;
  logic [NDATA*8-1:0]    r_shift;
  logic                  r_enable, r_single, r_irq_en;
  logic [PERIOD_W-1:0]   r_period, r_tick_cnt;
  logic                  r_data_valid, r_overrun;
  logic [11:0]           r_x, r_y, r_z;
  logic [31:0]           r_sample_cnt;
`ifdef ADXL_TEMP_EN
  logic [11:0]           r_temp;
`endif

  logic       w_tick, w_wr, w_rd_z, w_capture, w_commit;
  logic [7:0] w_tx_byte;

  assign w_wr   = i_cs & i_write;
  assign w_rd_z = i_cs & i_read & (i_addr == 5'd5);
  assign w_tick = r_enable & ((r_period == '0) | (r_tick_cnt >= (r_period - 1'b1)));
  assign w_tx_byte = (r_byte_idx == 4'd0) ? 8'h0B :
                     (r_byte_idx == 4'd1) ? 8'h0E : 8'h00;
  assign o_irq = r_data_valid & r_irq_en;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_spi_start   = 1'b0;
    o_spi_wr_byte = 8'h00;
    o_spi_ss_n    = 1'b0;
    w_capture     = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_spi_ss_n = 1'b1;
        if (w_tick | r_single) w_state_nxt = S_SETUP;
      end
      S_SETUP: if (r_cyc_cnt == 4'(SS_SETUP_CYC - 1)) w_state_nxt = S_SEND;
      S_SEND: begin
        o_spi_wr_byte = w_tx_byte;
        if (i_spi_ready) begin
          o_spi_start = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        o_spi_wr_byte = w_tx_byte;
        // Only a ready that dropped after the start marks a finished byte.
        if (r_seen_low & i_spi_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_byte_idx == 4'(NBYTES - 1)) ? S_COMMIT : S_SEND;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        o_spi_ss_n = 1'b1;
        if (r_cyc_cnt == 4'(SS_HOLD_CYC - 1)) w_state_nxt = S_IDLE;
      end
      default: begin
        o_spi_ss_n  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cyc_cnt  <= '0;
      r_byte_idx <= '0;
      r_seen_low <= 1'b0;
      r_shift    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_cyc_cnt <= (w_state_nxt != r_state) ? 4'd0 : r_cyc_cnt + 4'd1;
      if (r_state == S_IDLE) r_byte_idx <= '0;
      else if (w_capture)    r_byte_idx <= r_byte_idx + 4'd1;
      if (r_state == S_SEND)                  r_seen_low <= 1'b0;
      else if (r_state == S_WAIT && !i_spi_ready) r_seen_low <= 1'b1;
      // Data bytes shift in from the top so XL ends up in the low byte.
      if (w_capture && r_byte_idx > 4'd1) r_shift <= {i_spi_rd_byte, r_shift[NDATA*8-1:8]};
      if (!r_enable || w_tick) r_tick_cnt <= '0;
      else                     r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_enable     <= 1'b0;
      r_single     <= 1'b0;
      r_irq_en     <= 1'b0;
      r_period     <= PERIOD_W'(RESET_PERIOD);
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_sample_cnt <= '0;
`ifdef ADXL_TEMP_EN
      r_temp       <= '0;
`endif
    end else begin
      if (w_commit) r_single <= 1'b0;
      if (w_wr && i_addr == 5'd0) begin
        r_enable <= i_wr_data[0];
        r_single <= i_wr_data[1];
        r_irq_en <= i_wr_data[2];
      end
      if (w_wr && i_addr == 5'd1) r_period <= i_wr_data[PERIOD_W-1:0];
      if (w_wr && i_addr == 5'd2 && i_wr_data[2]) r_overrun <= 1'b0;
      if (w_rd_z) r_data_valid <= 1'b0;
      if (w_commit) begin
        r_x          <= r_shift[11:0];
        r_y          <= r_shift[27:16];
        r_z          <= r_shift[43:32];
`ifdef ADXL_TEMP_EN
        r_temp       <= r_shift[59:48];
`endif
        r_sample_cnt <= r_sample_cnt + 32'd1;
        r_data_valid <= 1'b1;
        // A sample consumed by a Z read in this very cycle is not an overrun.
        if (r_data_valid && !w_rd_z) r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_data = 32'd0;
    case (i_addr)
      5'd0: o_rd_data = {29'd0, r_irq_en, r_single, r_enable};
      5'd1: o_rd_data = 32'(r_period);
      5'd2: o_rd_data = {29'd0, r_overrun, r_data_valid, (r_state != S_IDLE)};
      5'd3: o_rd_data = {{20{r_x[11]}}, r_x};
      5'd4: o_rd_data = {{20{r_y[11]}}, r_y};
      5'd5: o_rd_data = {{20{r_z[11]}}, r_z};
      5'd6: o_rd_data = r_sample_cnt;
`ifdef ADXL_TEMP_EN
      5'd7: o_rd_data = {{20{r_temp[11]}}, r_temp};
`endif
      default: o_rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_adxl362_poll_ctrl.sv
// Randomized bench for adxl362_poll_ctrl: SPI slave model with random latency and data,
// reference model of the register file updated per completed frame.
module tb_adxl362_poll_ctrl;
`ifdef ADXL_TEMP_EN
  localparam int NDATA = 8;
`else
  localparam int NDATA = 6;
`endif
  localparam int NBYTES = NDATA + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        spi_start, spi_ready, spi_ss_n, irq;
  logic [7:0]  spi_wr_byte, spi_rd_byte;

  always #5 clk = ~clk;

  adxl362_poll_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_cs(cs), .i_read(rd), .i_write(wr),
    .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd_data),
    .o_spi_start(spi_start), .o_spi_wr_byte(spi_wr_byte),
    .i_spi_rd_byte(spi_rd_byte), .i_spi_ready(spi_ready),
    .o_spi_ss_n(spi_ss_n), .o_irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference register state
  logic        exp_en, exp_irq_en, exp_dv, exp_ovr;
  logic [31:0] exp_period, exp_cnt, exp_x, exp_y, exp_z, exp_t;

  function automatic logic [31:0] sx12(input logic [7:0] l, input logic [7:0] h);
    logic [11:0] v;
    v = {h[3:0], l};
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [7:0] exp_mosi(input int k);
    return (k == 0) ? 8'h0B : (k == 1) ? 8'h0E : 8'h00;
  endfunction

  function automatic logic [31:0] exp_reg(input logic [4:0] a);
    case (a)
      5'd0: return {29'd0, exp_irq_en, 1'b0, exp_en};
      5'd1: return exp_period;
      5'd2: return {29'd0, exp_ovr, exp_dv, 1'b0};
      5'd3: return exp_x;
      5'd4: return exp_y;
      5'd5: return exp_z;
      5'd6: return exp_cnt;
`ifdef ADXL_TEMP_EN
      5'd7: return exp_t;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    exp_en = 0; exp_irq_en = 0; exp_dv = 0; exp_ovr = 0;
    exp_period = 32'd100000; exp_cnt = 0;
    exp_x = 0; exp_y = 0; exp_z = 0; exp_t = 0;
  endtask

  // SPI slave model
  int          cyc = 0;
  int          busy_cnt = 0;
  bit          armed = 0;
  int          cur_k = 0;
  bit          in_frame = 0;
  bit          mosi_ok = 1;
  bit          prev_ss = 1;
  int          frames_done = 0;
  int          starts_q[$];
  logic [7:0]  data_b [10];
  logic [7:0]  fixed_bytes [10];
  bit          fixed_en = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; armed = 0; cur_k = 0; in_frame = 0; prev_ss = 1;
      spi_ready = 1'b1;
    end else begin
      if (prev_ss && !spi_ss_n) begin
        in_frame = 1; cur_k = 0; mosi_ok = 1;
        starts_q.push_back(cyc);
      end
      if (!prev_ss && spi_ss_n && in_frame) begin
        in_frame = 0;
        check_eq("frame_len", cur_k, NBYTES);
        check_eq("frame_mosi", 32'(mosi_ok), 32'd1);
        exp_ovr = exp_ovr | exp_dv;
        exp_dv  = 1;
        exp_cnt = exp_cnt + 1;
        exp_x = sx12(data_b[0], data_b[1]);
        exp_y = sx12(data_b[2], data_b[3]);
        exp_z = sx12(data_b[4], data_b[5]);
        if (NDATA > 6) exp_t = sx12(data_b[6], data_b[7]);
        frames_done++;
      end
      prev_ss = spi_ss_n;
      if (armed) begin
        armed = 0;
        spi_ready = 1'b0;
        busy_cnt = $urandom_range(1, 4);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          spi_rd_byte = (cur_k >= 2) ? data_b[cur_k-2] : 8'($urandom);
          spi_ready = 1'b1;
          cur_k++;
        end
      end else if (spi_start) begin
        if (spi_wr_byte !== exp_mosi(cur_k)) mosi_ok = 0;
        if (cur_k >= 2 && cur_k < 10) data_b[cur_k-2] = fixed_en ? fixed_bytes[cur_k-2] : 8'($urandom);
        armed = 1;
      end
    end
  end

  task automatic cpu_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1; wr = 1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic cpu_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1; rd = 1; addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 0; rd = 0;
  endtask

  task automatic check_reg(input logic [4:0] a);
    logic [31:0] d;
    cpu_rd(a, d);
    check_eq($sformatf("reg%0d", a), d, exp_reg(a));
    if (a == 5'd5) exp_dv = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge clk); #1; t++;
    end
    check_eq("frames_reached", frames_done, n);
  endtask

  task automatic wait_k(input int k, input int budget);
    int t = 0;
    while (!(in_frame && cur_k >= k) && t < budget) begin
      @(negedge clk); #1; t++;
    end
    check_eq("byte_progress", 32'(in_frame && cur_k >= k), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int f, n;
    rst = 1; cs = 0; rd = 0; wr = 0; addr = 0; wr_data = 0;
    spi_ready = 1; spi_rd_byte = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ss_n", 32'(spi_ss_n), 32'd1);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_start", 32'(spi_start), 32'd0);
    check_eq("rst_wr_byte", 32'(spi_wr_byte), 32'd0);
    rst = 0;
    for (int a = 0; a < 8; a++) check_reg(5'(a));
    cpu_wr(5'd9, 32'hFFFF_FFFF);
    check_reg(5'd9);
    check_reg(5'd31);

    // Single frame, fixed data
    fixed_bytes[0] = 8'h34; fixed_bytes[1] = 8'h01; fixed_bytes[2] = 8'hFF;
    fixed_bytes[3] = 8'h0F; fixed_bytes[4] = 8'h00; fixed_bytes[5] = 8'h08;
    fixed_bytes[6] = 8'h10; fixed_bytes[7] = 8'h02;
    fixed_en = 1;
    cpu_wr(5'd1, 32'd0); exp_period = 0;
    cpu_wr(5'd0, 32'h2);
    wait_frames(1, 600);
    repeat (8) @(negedge clk);
    check_reg(5'd2);
    check_reg(5'd0);
    cpu_rd(5'd3, d); check_eq("x_fixed", d, 32'h0000_0134);
    check_reg(5'd4);
    check_reg(5'd5);
    check_reg(5'd6);
    check_reg(5'd7);
    check_reg(5'd2);
    fixed_en = 0;

    // Periodic frames with overrun and irq
    cpu_wr(5'd1, 32'd1000); exp_period = 1000;
    cpu_wr(5'd0, 32'h5); exp_en = 1; exp_irq_en = 1;
    f = frames_done;
    wait_frames(f + 3, 3800);
    n = starts_q.size();
    check_eq("period_a", starts_q[n-1] - starts_q[n-2], 32'd1000);
    check_eq("period_b", starts_q[n-2] - starts_q[n-3], 32'd1000);
    repeat (8) @(negedge clk);
    check_reg(5'd2);
    check_reg(5'd3);
    check_reg(5'd4);
    repeat (50) @(negedge clk);
    check_eq("irq_high", 32'(irq), 32'd1);
    check_reg(5'd5);
    @(negedge clk);
    check_eq("irq_low", 32'(irq), 32'd0);
    check_reg(5'd2);
    cpu_wr(5'd2, 32'h4); exp_ovr = 0;
    check_reg(5'd2);
    check_reg(5'd6);

    // Disable during the third data byte: frame still completes
    f = frames_done;
    wait_k(4, 1500);
    cpu_wr(5'd0, 32'h4); exp_en = 0;
    wait_frames(f + 1, 600);
    repeat (8) @(negedge clk);
    check_reg(5'd2);
    check_reg(5'd6);
    check_reg(5'd3);
    check_eq("irq_after_disable", 32'(irq), 32'd1);
    repeat (2500) @(negedge clk);
    check_eq("no_more_frames", frames_done, f + 1);
    check_eq("idle_ss_n", 32'(spi_ss_n), 32'd1);

    // Async reset mid-frame
    cpu_wr(5'd1, 32'd0); exp_period = 0;
    cpu_wr(5'd0, 32'h2);
    wait_k(4, 600);
    #2 rst = 1;
    #1 check_eq("rst_mid_ss_n", 32'(spi_ss_n), 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check_reg(5'd1);
    check_reg(5'd2);
    check_reg(5'd3);
    check_reg(5'd4);
    check_reg(5'd5);
    check_reg(5'd6);
    cpu_wr(5'd1, 32'd0); exp_period = 0;
    cpu_wr(5'd0, 32'h2);
    f = frames_done;
    wait_frames(f + 1, 600);
    repeat (8) @(negedge clk);
    check_reg(5'd3);
    check_reg(5'd7);
    check_reg(5'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
